// File: rtl/restoring_divider_seq_pkg.sv
// restoring_divider_seq_pkg: shared FSM state encoding and defaults for the divide unit
package restoring_divider_seq_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/restoring_divider_seq_if.sv
// restoring_divider_seq_if: start/busy/done handshake and operand/result bus of the divider
//   master: drives i_start, i_dividend, i_divisor; observes o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
//   slave : the divider side of the same signals
interface restoring_divider_seq_if import restoring_divider_seq_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic             i_start;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_by_zero;
    modport master (output i_start, i_dividend, i_divisor,
                    input  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
    modport slave  (input  i_start, i_dividend, i_divisor,
                    output o_busy, o_done, o_quotient, o_remainder, o_div_by_zero);
endinterface

// File: rtl/restoring_divider_seq_sub.sv
// ripple_subtractor_n: N-bit full-subtractor chain, i_in1 - i_in2 - i_bin -> o_diff with borrow-out o_bout
module ripple_subtractor_n #(parameter int N = 9) (
    input  logic [N-1:0] i_in1,
    input  logic [N-1:0] i_in2,
    input  logic         i_bin,
    output logic [N-1:0] o_diff,
    output logic         o_bout
);
    logic [N:0] w_b;
    assign w_b[0] = i_bin;
    for (genvar i = 0; i < N; i++) begin : g_fs
        assign o_diff[i] = i_in1[i] ^ i_in2[i] ^ w_b[i];
        assign w_b[i+1]  = (~i_in1[i] & i_in2[i]) | (~(i_in1[i] ^ i_in2[i]) & w_b[i]);
    end
    assign o_bout = w_b[N];
endmodule

// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq: sequential unsigned restoring divider, one quotient bit per clock
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of restoring_divider_seq_if (start/operands in, busy/done/results out)
module restoring_divider_seq import restoring_divider_seq_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input logic                    clk,
    input logic                    rst,
    restoring_divider_seq_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_q, r_div, r_quo, r_rmd;
    logic             r_busy, r_done, r_dbz;
    logic [WIDTH:0]   w_shift, w_diff;
    logic [WIDTH-1:0] w_rem_nxt, w_q_nxt;
    logic             w_bout, w_zero, w_unused;
    // Shifted partial remainder needs WIDTH+1 bits: it can reach 2*divisor-1.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    ripple_subtractor_n #(.N(WIDTH + 1)) u_sub (
        .i_in1  (w_shift),
        .i_in2  ({1'b0, r_div}),
        .i_bin  (1'b0),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );
    // On borrow the shifted value is below divisor, so its top bit is zero and truncation is safe.
    assign w_rem_nxt = w_bout ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_bout};
    assign w_zero    = bus.i_divisor == '0;
    assign w_unused  = w_diff[WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_quo   <= '0;
            r_rmd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.i_start) begin
                    r_state <= w_zero ? ST_FIN : ST_RUN;
                    r_busy  <= ~w_zero;
                    r_done  <= w_zero;
                    r_dbz   <= w_zero;
                    r_quo   <= w_zero ? '1 : '0;
                    r_rmd   <= w_zero ? bus.i_dividend : '0;
                    r_rem   <= '0;
                    r_q     <= bus.i_dividend;
                    r_div   <= bus.i_divisor;
                    r_cnt   <= CNT_INIT;
                end
                ST_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    // Results are registered on the last step so done and data appear together in FIN.
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quo   <= w_q_nxt;
                        r_rmd   <= w_rem_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_quotient    = r_quo;
    assign bus.o_remainder   = r_rmd;
    assign bus.o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_restoring_divider_seq.sv
// tb_restoring_divider_seq: directed and random checks of restoring_divider_seq against plain arithmetic
module tb_restoring_divider_seq;
    localparam int W = 8;
    logic clk, rst;
    int n_vec = 0;
    int n_err = 0;
    restoring_divider_seq_if #(.WIDTH(W)) bus ();
    restoring_divider_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
        chk({tag, "_done"}, 32'(bus.o_done), 0);
        chk({tag, "_q"}, 32'(bus.o_quotient), 0);
        chk({tag, "_r"}, 32'(bus.o_remainder), 0);
        chk({tag, "_dbz"}, 32'(bus.o_div_by_zero), 0);
    endtask
    // Launch a/b; inj>0 raises start with different operands during that cycle of the run.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        int eq, er, ez, lat;
        ez  = (b == 0) ? 1 : 0;
        eq  = ez ? (1 << W) - 1 : int'(a) / int'(b);
        er  = ez ? int'(a) : int'(a) % int'(b);
        lat = ez ? 1 : W + 1;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_start    = 1'b1;
        tick();
        for (int n = 1; n <= lat; n++) begin
            bus.i_start = (n == inj);
            if (n == inj) begin
                bus.i_dividend = ~a;
                bus.i_divisor  = b + 8'd1;
            end
            chk("busy", 32'(bus.o_busy), (!ez && n <= W) ? 1 : 0);
            chk("done", 32'(bus.o_done), (n == lat) ? 1 : 0);
            if (n < lat) tick();
        end
        bus.i_start = 1'b0;
        chk("quot", 32'(bus.o_quotient), eq);
        chk("rem", 32'(bus.o_remainder), er);
        chk("dbz", 32'(bus.o_div_by_zero), ez);
        if (!ez) begin
            chk("inv_eq", 32'(bus.o_quotient) * 32'(b) + 32'(bus.o_remainder), 32'(a));
            chk("inv_lt", (bus.o_remainder < b) ? 1 : 0, 1);
        end
        tick();
        chk("done_pulse", 32'(bus.o_done), 0);
        chk("busy_idle", 32'(bus.o_busy), 0);
        chk("quot_hold", 32'(bus.o_quotient), eq);
        chk("rem_hold", 32'(bus.o_remainder), er);
    endtask
    initial begin
        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor = '0;
        tick();
        tick();
        chk_idle_zero("reset");
        rst = 1'b0;
        do_div(8'd100, 8'd7, 0);
        do_div(8'd255, 8'd1, 0);
        do_div(8'd255, 8'd255, 0);
        do_div(8'd0, 8'd13, 0);
        do_div(8'd5, 8'd9, 0);
        do_div(8'd200, 8'd3, 0);
        do_div(8'd77, 8'd0, 0);
        do_div(8'd10, 8'd2, 0);
        do_div(8'd100, 8'd7, 4);
        bus.i_dividend = 8'd100;
        bus.i_divisor  = 8'd7;
        bus.i_start    = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int n = 1; n < 5; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_zero("mid_rst");
        for (int n = 0; n < 12; n++) begin
            chk("rst_no_done", 32'(bus.o_done), 0);
            tick();
        end
        do_div(8'd10, 8'd2, 0);
        for (int k = 0; k < 1000; k++)
            do_div(W'($urandom), W'($urandom_range(0, 255)), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
